cnt_dly_macrocell: RTL and testbench
====================================

Name: cnt_dly_macrocell

Overview:
- Behavioural model of one SLG46620 CNT/DLY macrocell. It consumes the cnt0 configuration encodings (clock source, edge/reset mode, function select) and implements counter, delay and edge-detect functions.
- Sits downstream of the clock-strobe generator and the configuration register file.
- Acts as the verification DUT and golden model for macrocell config decoding.

Parameters:
- WIDTH, 14, counter/delay data width (counter value range 0..2^WIDTH-1)
- NSRC, 13, number of valid clock-source strobes (select codes 0..12)

Ports:
- clk  input  1  single system clock; all logic on its rising edge
- rst_n  input  1  reset, asynchronous, active-low
- cfg_ck_sel  input  4  clock source select code (0..12 valid, 13..15 reserved)
- cfg_edge_mode  input  2  DLY/edge-detect: 00 both, 01 falling, 10 rising, 11 none; CNT: 00 both-edge reset, 01 falling, 10 rising, 11 high-level reset
- cfg_func  input  2  00 DLY, 01 CNT, 10 Edge_Detect, 11 Wake_Sleep (reserved)
- cfg_data  input  WIDTH  counter reload / delay length / pulse length
- ck_src_tick  input  NSRC  one-cycle clock-enable strobes, indexed by select code
- ext_in  input  1  macrocell input, already synchronous to clk
- dly_out  output  1  DLY or edge-detect output level
- cnt_end  output  1  one-cycle pulse at counter terminal count
- cnt_val  output  WIDTH  current counter value
- cfg_err  output  1  reserved clock code or reserved function selected

Behaviour:
- Reset (rst_n=0, asynchronous): FSM=IDLE, cnt_val=0, dly_out=0, cnt_end=0, in_q=0. cfg_err is combinational.
- tick = ck_src_tick[cfg_ck_sel] for codes 0..NSRC-1; codes 13..15 give tick=0 and cfg_err=1. cfg_func=11 also sets cfg_err=1; in that case the FSM is held in IDLE and outputs are held at reset values.
- Edge detection: in_q registers ext_in every cycle. rise = ext_in & ~in_q; fall = ~ext_in & in_q. Qualified edge (qe) is selected by cfg_edge_mode; mode 11 gives qe=0 in DLY/ED.
- FSM states: IDLE, RUN. A cfg_func value differing from the previous cycle forces IDLE on the next edge with cnt_val=0 and dly_out=0.
- CNT mode:
  - IDLE -> RUN on the next clk, loading cnt_val=cfg_data.
  - In RUN, each tick decrements cnt_val. A tick with cnt_val==0 reloads cfg_data and registers cnt_end=1 for exactly one clk. Period is cfg_data+1 ticks.
  - Reset condition (edge per mode 00/01/10, or ext_in==1 for mode 11) reloads cfg_data and suppresses cnt_end. Reset has priority over a simultaneous tick.
  - In mode 11 the counter is held at cfg_data for as long as ext_in is high.
  - dly_out=0 in CNT.
- DLY mode:
  - A qe in IDLE loads cnt_val=cfg_data and enters RUN.
  - Each tick in RUN decrements cnt_val. A tick at cnt_val==0 sets dly_out<=ext_in on the next clk and returns to IDLE. Delay is cfg_data+1 ticks plus 1 clk.
  - If ext_in returns to dly_out's level during RUN, go to IDLE with no output change (glitch filter).
  - A non-qualified edge propagates to dly_out one clk later. Mode 11: dly_out=0 constantly.
- Edge_Detect mode:
  - A qe sets dly_out=1 next clk, loads cfg_data and enters RUN.
  - Ticks decrement; a tick at 0 clears dly_out and returns to IDLE. Pulse width is cfg_data+1 ticks.
  - A qe during RUN retriggers (reload, dly_out stays 1).
- cfg_data=0: CNT gives cnt_end on every tick; DLY/ED expire on the first tick.
- No wrap below 0: the decrement is never applied at 0.
- cfg_ck_sel change mid-RUN: the count continues on the new source without a restart.
- Asynchronous reset mid-RUN: immediate return to reset values; no cnt_end is emitted.

Test Plan:
- CNT, cfg_data=3, cfg_ck_sel=0, tick every cycle -> cnt_val 3,2,1,0,3…; cnt_end one clk wide every 4 ticks; first pulse 5 clks after reset release.
- CNT, mode 11, cfg_data=5, ext_in high for 10 clks mid-count -> cnt_val held at 5, no cnt_end; counting resumes on the first tick after ext_in falls.
- DLY rising, cfg_data=2, tick every 2nd clk (code 1), ext_in 0->1 held -> dly_out rises after 3 ticks +1 clk. A 1-clk ext_in pulse -> dly_out stays 0.
- Edge_Detect both, cfg_data=4, rise then fall 2 ticks apart -> single retriggered pulse lasting 7 ticks total.
- cfg_ck_sel=13 or cfg_func=11 -> cfg_err=1, tick=0, cnt_val frozen / outputs 0. Switching back to a valid code -> cfg_err=0 the same cycle.
- rst_n low mid-DLY RUN with cnt_val=7 -> cnt_val=0, dly_out=0, cnt_end=0 immediately without a clock edge.

Source files
------------

// File: rtl/cnt_dly_if.sv
// cnt_dly_if
// Groups the configuration, strobe, input and status signals of one CNT/DLY
// macrocell so that the macrocell and its driver connect through one port.
//   cfg_ck_sel    : clock-source select code (0..NSRC-1 valid)
//   cfg_edge_mode : edge / reset mode
//   cfg_func      : 00 DLY, 01 CNT, 10 edge detect, 11 wake/sleep (reserved)
//   cfg_data      : reload / delay / pulse length
//   ck_src_tick   : one-cycle clock-enable strobes, one per source
//   ext_in        : macrocell input, synchronous to clk
//   dly_out       : DLY / edge-detect output level
//   cnt_end       : one-cycle terminal-count pulse
//   cnt_val       : current counter value
//   cfg_err       : reserved clock code or reserved function selected
// master drives configuration and inputs; slave is the macrocell.
interface cnt_dly_if #(
    parameter int WIDTH = 14,
    parameter int NSRC  = 13
) ();
    logic [3:0]       cfg_ck_sel;
    logic [1:0]       cfg_edge_mode;
    logic [1:0]       cfg_func;
    logic [WIDTH-1:0] cfg_data;
    logic [NSRC-1:0]  ck_src_tick;
    logic             ext_in;
    logic             dly_out;
    logic             cnt_end;
    logic [WIDTH-1:0] cnt_val;
    logic             cfg_err;

    modport master (
        output cfg_ck_sel, cfg_edge_mode, cfg_func, cfg_data, ck_src_tick, ext_in,
        input  dly_out, cnt_end, cnt_val, cfg_err
    );

    modport slave (
        input  cfg_ck_sel, cfg_edge_mode, cfg_func, cfg_data, ck_src_tick, ext_in,
        output dly_out, cnt_end, cnt_val, cfg_err
    );
endinterface

// File: rtl/cnt_dly_macrocell.sv
// cnt_dly_macrocell
// Behavioural model of one CNT/DLY macrocell: free-running counter with
// terminal-count pulse, glitch-filtering delay line, and retriggerable
// edge-detect pulse generator, all timed by a selectable clock-enable strobe.
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : cnt_dly_if slave (configuration, strobes, ext_in, outputs)
//
// state | meaning
// IDLE  | not timing; CNT loads on next clk, DLY/ED wait for a qualified edge
// RUN   | counting down on ticks of the selected clock source
module cnt_dly_macrocell #(
    parameter int WIDTH = 14,
    parameter int NSRC  = 13
) (
    input  logic      clk,
    input  logic      rst_n,
    cnt_dly_if.slave  bus
);
    localparam logic [1:0] FUNC_DLY = 2'b00;
    localparam logic [1:0] FUNC_CNT = 2'b01;
    localparam logic [1:0] FUNC_ED  = 2'b10;
    localparam logic [1:0] FUNC_WS  = 2'b11;
    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;

    state_t           r_state, w_state_nx;
    logic [WIDTH-1:0] r_cnt, w_cnt_nx;
    logic             r_dly, w_dly_nx;
    logic             r_end, w_end_nx;
    logic             r_in_q;
    logic [1:0]       r_func_q;
    logic             r_func_vld;

    logic w_code_ok, w_tick, w_rise, w_fall, w_qe, w_crst, w_func_chg;

    always_comb begin
        w_code_ok = (int'(bus.cfg_ck_sel) < NSRC);
        w_tick    = 1'b0;
        for (int i = 0; i < NSRC; i++) begin
            if (int'(bus.cfg_ck_sel) == i) w_tick = bus.ck_src_tick[i];
        end
    end

    assign bus.cfg_err = ~w_code_ok | (bus.cfg_func == FUNC_WS);

    // qe qualifies DLY/ED triggers; crst is the CNT reload condition, which
    // in mode 11 is a level rather than an edge.
    always_comb begin
        w_rise = bus.ext_in & ~r_in_q;
        w_fall = ~bus.ext_in & r_in_q;
        w_qe   = 1'b0;
        w_crst = 1'b0;
        case (bus.cfg_edge_mode)
            2'b00: begin w_qe = w_rise | w_fall; w_crst = w_rise | w_fall; end
            2'b01: begin w_qe = w_fall;          w_crst = w_fall;          end
            2'b10: begin w_qe = w_rise;          w_crst = w_rise;          end
            default: begin w_qe = 1'b0;          w_crst = bus.ext_in;      end
        endcase
    end

    // r_func_vld masks the first cycle after reset so the initial function
    // value is not mistaken for a change.
    assign w_func_chg = r_func_vld & (bus.cfg_func != r_func_q);

    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_dly_nx   = r_dly;
        w_end_nx   = 1'b0;
        if (bus.cfg_func == FUNC_WS || w_func_chg) begin
            w_state_nx = ST_IDLE;
            w_cnt_nx   = '0;
            w_dly_nx   = 1'b0;
        end else begin
            case (bus.cfg_func)
                FUNC_CNT: begin
                    w_dly_nx = 1'b0;
                    if (r_state == ST_IDLE) begin
                        w_state_nx = ST_RUN;
                        w_cnt_nx   = bus.cfg_data;
                    end else if (w_crst) begin
                        w_cnt_nx = bus.cfg_data;
                    end else if (w_tick) begin
                        if (r_cnt == '0) begin
                            w_cnt_nx = bus.cfg_data;
                            w_end_nx = 1'b1;
                        end else begin
                            w_cnt_nx = r_cnt - ONE;
                        end
                    end
                end
                FUNC_DLY: begin
                    if (bus.cfg_edge_mode == 2'b11) begin
                        w_state_nx = ST_IDLE;
                        w_dly_nx   = 1'b0;
                    end else if (r_state == ST_IDLE) begin
                        if (w_qe) begin
                            w_state_nx = ST_RUN;
                            w_cnt_nx   = bus.cfg_data;
                        end else if (w_rise | w_fall) begin
                            w_dly_nx = bus.ext_in;
                        end
                    end else if (bus.ext_in == r_dly) begin
                        // input fell back before the delay expired: drop it
                        w_state_nx = ST_IDLE;
                    end else if (w_tick) begin
                        if (r_cnt == '0) begin
                            w_dly_nx   = bus.ext_in;
                            w_state_nx = ST_IDLE;
                        end else begin
                            w_cnt_nx = r_cnt - ONE;
                        end
                    end
                end
                FUNC_ED: begin
                    if (w_qe) begin
                        w_state_nx = ST_RUN;
                        w_dly_nx   = 1'b1;
                        w_cnt_nx   = bus.cfg_data;
                    end else if (r_state == ST_RUN && w_tick) begin
                        if (r_cnt == '0) begin
                            w_dly_nx   = 1'b0;
                            w_state_nx = ST_IDLE;
                        end else begin
                            w_cnt_nx = r_cnt - ONE;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_dly      <= 1'b0;
            r_end      <= 1'b0;
            r_in_q     <= 1'b0;
            r_func_q   <= 2'b00;
            r_func_vld <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            r_cnt      <= w_cnt_nx;
            r_dly      <= w_dly_nx;
            r_end      <= w_end_nx;
            r_in_q     <= bus.ext_in;
            r_func_q   <= bus.cfg_func;
            r_func_vld <= 1'b1;
        end
    end

    assign bus.dly_out = r_dly;
    assign bus.cnt_end = r_end;
    assign bus.cnt_val = r_cnt;
endmodule

// File: tb/tb_cnt_dly_macrocell.sv
module tb_cnt_dly_macrocell;
    localparam int WIDTH = 14;
    localparam int NSRC  = 13;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cnt_dly_if #(.WIDTH(WIDTH), .NSRC(NSRC)) bus ();
    cnt_dly_macrocell #(.WIDTH(WIDTH), .NSRC(NSRC)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    typedef struct {
        int cnt;
        bit dly;
        bit cend;
        bit err;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_pass = 0;
    int   tcyc = 0;
    bit   mon_en = 1'b0;

    // reference model: remaining ticks until expiry / period end (0 = nothing loaded)
    bit m_run, m_out, m_end, m_inprev, m_fvld;
    int m_rem, m_fprev;

    task automatic chk(input string name, input bit ok, input string detail);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s %s", name, detail);
    endtask

    task automatic model_reset();
        m_run = 0; m_out = 0; m_end = 0; m_inprev = 0; m_fvld = 0;
        m_rem = 0; m_fprev = 0;
    endtask

    function automatic bit edge_sel(input int mode, input bit r, input bit f);
        if (mode == 0) return r | f;
        if (mode == 1) return f;
        if (mode == 2) return r;
        return 1'b0;
    endfunction

    task automatic model_step(input int ck, input int mode, input int func, input int data,
                              input logic [NSRC-1:0] ticks, input bit ext, output exp_t e);
        bit tick, r, f;
        tick = 1'b0;
        if (ck < NSRC) tick = ticks[ck];
        r = ext & ~m_inprev;
        f = ~ext & m_inprev;
        m_end = 0;
        if (func == 3 || (m_fvld && func != m_fprev)) begin
            m_run = 0; m_rem = 0; m_out = 0;
        end else if (func == 1) begin
            m_out = 0;
            if (!m_run) begin
                m_run = 1; m_rem = data + 1;
            end else if (edge_sel(mode, r, f) || (mode == 3 && ext)) begin
                m_rem = data + 1;
            end else if (tick) begin
                m_rem--;
                if (m_rem == 0) begin m_end = 1; m_rem = data + 1; end
            end
        end else if (func == 0) begin
            if (mode == 3) begin
                m_run = 0; m_out = 0;
            end else if (!m_run) begin
                if (edge_sel(mode, r, f)) begin m_run = 1; m_rem = data + 1; end
                else if (r | f) m_out = ext;
            end else if (ext == m_out) begin
                m_run = 0;
            end else if (tick) begin
                m_rem--;
                if (m_rem == 0) begin m_out = ext; m_run = 0; end
            end
        end else begin
            if (edge_sel(mode, r, f)) begin
                m_run = 1; m_out = 1; m_rem = data + 1;
            end else if (m_run && tick) begin
                m_rem--;
                if (m_rem == 0) begin m_out = 0; m_run = 0; end
            end
        end
        m_inprev = ext; m_fprev = func; m_fvld = 1;
        e.cnt  = (m_rem > 0) ? m_rem - 1 : 0;
        e.dly  = m_out;
        e.cend = m_end;
        e.err  = (ck >= NSRC) || (func == 3);
    endtask

    function automatic logic [NSRC-1:0] mk_ticks(input int c, input bit rnd);
        logic [NSRC-1:0] t;
        t = NSRC'($urandom);
        if (!rnd) begin
            t[0] = 1'b1;
            t[1] = c[0];
        end
        return t;
    endfunction

    // called at a negedge; returns at the following negedge
    task automatic drive_cycle(input int ck, input int mode, input int func, input int data,
                               input bit ext, input bit rnd);
        exp_t e;
        logic [NSRC-1:0] t;
        t = mk_ticks(tcyc, rnd);
        bus.cfg_ck_sel    = 4'(ck);
        bus.cfg_edge_mode = 2'(mode);
        bus.cfg_func      = 2'(func);
        bus.cfg_data      = WIDTH'(data);
        bus.ck_src_tick   = t;
        bus.ext_in        = ext;
        model_step(ck, mode, func, data, t, ext, e);
        sb_q.push_back(e);
        tcyc++;
        @(negedge clk);
    endtask

    always @(posedge clk) begin
        if (mon_en) begin
            #1;
            if (sb_q.size() == 0) begin
                chk("sb_underflow", 1'b0, "no expected entry for DUT output");
            end else begin
                mon_e = sb_q.pop_front();
                chk("cycle", (int'(bus.cnt_val) == mon_e.cnt) && (bus.dly_out === mon_e.dly) &&
                             (bus.cnt_end === mon_e.cend) && (bus.cfg_err === mon_e.err),
                    $sformatf("t=%0t got cnt=%0d dly=%b end=%b err=%b, want cnt=%0d dly=%b end=%b err=%b",
                              $time, bus.cnt_val, bus.dly_out, bus.cnt_end, bus.cfg_err,
                              mon_e.cnt, mon_e.dly, mon_e.cend, mon_e.err));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int hi, func, mode, ck, data;
        bit ext;
        bus.cfg_ck_sel = 4'd0; bus.cfg_edge_mode = 2'b00; bus.cfg_func = 2'b01;
        bus.cfg_data = WIDTH'(3); bus.ck_src_tick = '0; bus.ext_in = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("reset_state", bus.cnt_val == '0 && bus.dly_out == 1'b0 && bus.cnt_end == 1'b0,
            $sformatf("got cnt=%0d dly=%b end=%b, want 0 0 0", bus.cnt_val, bus.dly_out, bus.cnt_end));

        // CNT, data 3, tick every clk: first cnt_end 5 clks after release
        rst_n = 1'b1;
        mon_en = 1'b1;
        repeat (4) drive_cycle(0, 0, 1, 3, 0, 0);
        chk("cnt_pre_end", bus.cnt_end == 1'b0 && bus.cnt_val == '0,
            $sformatf("got end=%b cnt=%0d, want 0 0", bus.cnt_end, bus.cnt_val));
        drive_cycle(0, 0, 1, 3, 0, 0);
        chk("cnt_first_end", bus.cnt_end == 1'b1 && int'(bus.cnt_val) == 3,
            $sformatf("got end=%b cnt=%0d, want 1 3", bus.cnt_end, bus.cnt_val));
        repeat (8) drive_cycle(0, 0, 1, 3, 0, 0);

        // CNT high-level reset holds at cfg_data
        repeat (3) drive_cycle(0, 3, 1, 5, 0, 0);
        repeat (10) drive_cycle(0, 3, 1, 5, 1, 0);
        chk("cnt_level_hold", int'(bus.cnt_val) == 5 && bus.cnt_end == 1'b0,
            $sformatf("got cnt=%0d end=%b, want 5 0", bus.cnt_val, bus.cnt_end));
        repeat (8) drive_cycle(0, 3, 1, 5, 0, 0);

        // DLY rising, data 2, tick every 2nd clk
        repeat (3) drive_cycle(1, 2, 0, 2, 0, 0);
        repeat (10) drive_cycle(1, 2, 0, 2, 1, 0);
        chk("dly_rise", bus.dly_out == 1'b1, $sformatf("got dly=%b, want 1", bus.dly_out));
        repeat (3) drive_cycle(1, 2, 0, 2, 0, 0);
        chk("dly_fall_pass", bus.dly_out == 1'b0, $sformatf("got dly=%b, want 0", bus.dly_out));
        drive_cycle(1, 2, 0, 2, 1, 0);
        repeat (8) drive_cycle(1, 2, 0, 2, 0, 0);
        chk("dly_glitch", bus.dly_out == 1'b0, $sformatf("got dly=%b, want 0", bus.dly_out));

        // Edge detect both edges, data 4, retrigger on the fall
        hi = 0;
        repeat (3) drive_cycle(0, 0, 2, 4, 0, 0);
        repeat (3) begin drive_cycle(0, 0, 2, 4, 1, 0); hi += int'(bus.dly_out); end
        repeat (12) begin drive_cycle(0, 0, 2, 4, 0, 0); hi += int'(bus.dly_out); end
        chk("ed_pulse_len", hi == 8, $sformatf("got %0d high clks, want 8", hi));

        // configuration errors
        bus.cfg_ck_sel = 4'd13;
        #1 chk("err_code13", bus.cfg_err == 1'b1, $sformatf("got err=%b, want 1", bus.cfg_err));
        bus.cfg_ck_sel = 4'd0;
        #1 chk("err_clear", bus.cfg_err == 1'b0, $sformatf("got err=%b, want 0", bus.cfg_err));
        repeat (4) drive_cycle(0, 0, 3, 4, 1, 0);
        repeat (3) drive_cycle(13, 0, 1, 3, 0, 0);
        chk("err_frozen", int'(bus.cnt_val) == 3 && bus.cfg_err == 1'b1,
            $sformatf("got cnt=%0d err=%b, want 3 1", bus.cnt_val, bus.cfg_err));
        repeat (3) drive_cycle(0, 0, 1, 3, 0, 0);

        // randomized phases
        ext = 0;
        for (int p = 0; p < 14; p++) begin
            func = ($urandom_range(0, 7) == 0) ? 3 : $urandom_range(0, 2);
            mode = $urandom_range(0, 3);
            ck   = ($urandom_range(0, 5) == 0) ? $urandom_range(13, 15) : $urandom_range(0, 12);
            data = ($urandom_range(0, 9) == 0) ? 16383 : $urandom_range(0, 6);
            for (int c = 0; c < 50; c++) begin
                if ($urandom_range(0, 4) == 0) ext = ~ext;
                if ($urandom_range(0, 19) == 0) ck = $urandom_range(0, 12);
                drive_cycle(ck, mode, func, data, ext, 1);
            end
        end

        // asynchronous reset in the middle of a DLY run
        repeat (3) drive_cycle(0, 2, 0, 9, 0, 0);
        repeat (3) drive_cycle(0, 2, 0, 9, 1, 0);
        chk("dly_mid_run", int'(bus.cnt_val) == 7, $sformatf("got cnt=%0d, want 7", bus.cnt_val));
        mon_en = 1'b0;
        #2 rst_n = 1'b0;
        #1 chk("async_reset", bus.cnt_val == '0 && bus.dly_out == 1'b0 && bus.cnt_end == 1'b0,
               $sformatf("got cnt=%0d dly=%b end=%b, want 0 0 0", bus.cnt_val, bus.dly_out, bus.cnt_end));
        chk("sb_drained", sb_q.size() == 0, $sformatf("got %0d entries left, want 0", sb_q.size()));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
